// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and decoder/ALU operation encodings.
package cpu_pkg;

  localparam int unsigned REG_WIDTH      = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG_IDX   = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_LOAD = 3'b110
  } op_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1,
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue_en,
  input  logic [ADDR_WIDTH-1:0] i_issue_rd,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  output logic [DEPTH-1:0]      o_busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  // Next busy vector: clear on writeback first, then set on issue so the newer producer wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_wen) begin
      w_busy_next[i_wr_addr] = 1'b0;
    end
    if (i_issue_en) begin
      w_busy_next[i_issue_rd] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      w_busy_next[ZERO_REG_IDX] = 1'b0;
    end
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_bypass.sv
// Multi-read-port register file with write-first bypass, optional zero register and RAW scoreboard.
module regfile_bypass
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = REG_WIDTH,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rs_addr,
  output logic [NUM_RD*WIDTH-1:0]      o_rs_data,
  output logic [NUM_RD-1:0]            o_rs_busy,
  input  logic                         i_wen,
  input  logic [ADDR_WIDTH-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic                         i_issue_en,
  input  logic [ADDR_WIDTH-1:0]        i_issue_rd,
  output logic                         o_hazard
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_bypass: NUM_RD must be in 1..4");
  end

  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_is_zero;
  logic              w_wr_valid;

  // Writes to the hardwired zero register are dropped.
  assign w_wr_is_zero = (ZERO_REG != 0) && (i_wr_addr == ADDR_WIDTH'(ZERO_REG_IDX));
  assign w_wr_valid   = i_wen && !w_wr_is_zero;

  // Register array write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_issue_en (i_issue_en),
    .i_issue_rd (i_issue_rd),
    .i_wen      (i_wen),
    .i_wr_addr  (i_wr_addr),
    .o_busy     (w_busy)
  );

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_addr_is_zero;
    logic                  w_wr_hit;
    logic [WIDTH-1:0]      r_data;

    assign w_addr         = i_rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_addr_is_zero = (ZERO_REG != 0) && (w_addr == ADDR_WIDTH'(ZERO_REG_IDX));
    assign w_wr_hit       = i_wen && (i_wr_addr == w_addr);

    // Registered read with write-first bypass; zero register always reads 0.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
      end else if (w_addr_is_zero) begin
        r_data <= '0;
      end else if (w_wr_valid && w_wr_hit) begin
        r_data <= i_wr_data;
      end else begin
        r_data <= r_regs[w_addr];
      end
    end

    assign o_rs_data[p*WIDTH +: WIDTH] = r_data;
    // A writeback landing this cycle resolves the hazard through the bypass.
    assign o_rs_busy[p] = w_busy[w_addr] && !w_wr_hit;
  end

  assign o_hazard = |o_rs_busy;

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass against an array-based reference model.
module tb_regfile_bypass;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic             clk;
  logic             rst;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*W-1:0]  rs_data;
  logic [NR-1:0]    rs_busy;
  logic             wen;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_data;
  logic             issue_en;
  logic [AW-1:0]    issue_rd;
  logic             hazard;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_regs [32];
  bit           m_busy [32];

  regfile_bypass #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .NUM_RD     (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rs_addr  (rs_addr),
    .o_rs_data  (rs_data),
    .o_rs_busy  (rs_busy),
    .i_wen      (wen),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_issue_en (issue_en),
    .i_issue_rd (issue_rd),
    .o_hazard   (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock of stimulus: check combinational busy/hazard, advance the model, check read data.
  task automatic cycle(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic ie, input logic [AW-1:0] ird);
    logic [AW-1:0] a [2];
    logic [W-1:0]  exp_d [2];
    logic          exp_b;
    logic          exp_h;
    a[0] = a0;
    a[1] = a1;
    rs_addr  = {a1, a0};
    wen      = we;
    wr_addr  = wa;
    wr_data  = wd;
    issue_en = ie;
    issue_rd = ird;
    #1;
    exp_h = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_b = m_busy[a[p]] && !(we && wa == a[p]);
      exp_h = exp_h | exp_b;
      check($sformatf("rs_busy[%0d]", p), 64'(rs_busy[p]), 64'(exp_b));
      if (a[p] == 0)                exp_d[p] = '0;
      else if (we && wa == a[p])    exp_d[p] = wd;
      else                          exp_d[p] = m_regs[a[p]];
    end
    check("hazard", 64'(hazard), 64'(exp_h));
    if (we && wa != 0) m_regs[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (ie && ird != 0) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rs_data[%0d]", p), 64'(rs_data[p*W +: W]), 64'(exp_d[p]));
    end
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    rs_addr = '0; wen = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0;
    model_reset();
    #12;
    check("reset rs_data", 64'(rs_data), 64'(0));
    check("reset hazard", 64'(hazard), 64'(0));
    check("reset rs_busy", 64'(rs_busy), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Prior write to r1 and a pending issue to r2, then asynchronous reset between edges.
    cycle(5'd0, 5'd0, 1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd2);
    cycle(5'd1, 5'd2, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    rs_addr = {5'd2, 5'd1};
    #2;
    rst = 1'b1;
    #1;
    check("async rst rs_data0", 64'(rs_data[0 +: W]), 64'(0));
    check("async rst rs_data1", 64'(rs_data[W +: W]), 64'(0));
    check("async rst hazard", 64'(hazard), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(5'd1, 5'd2, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // Basic write then read on both ports.
    cycle(5'd0, 5'd0, 1'b1, 5'd3, 32'h0000000E, 1'b0, 5'd0);
    cycle(5'd3, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // Same-cycle bypass on port 1.
    cycle(5'd0, 5'd5, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);

    // Zero register ignores writes and issues.
    cycle(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // Scoreboard set, then resolve via writeback.
    cycle(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    cycle(5'd7, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    check("r7 hazard direct", 64'(m_busy[7]), 64'(1));
    cycle(5'd7, 5'd0, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0);
    cycle(5'd7, 5'd7, 1'b0, 5'd0, '0, 1'b0, 5'd0);

    // Simultaneous issue and write to a busy register keeps it busy.
    cycle(5'd0, 5'd0, 1'b0, 5'd0, '0, 1'b1, 5'd4);
    cycle(5'd4, 5'd0, 1'b1, 5'd4, 32'h9, 1'b1, 5'd4);
    cycle(5'd4, 5'd4, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    idle();

    // Randomized traffic focused on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 100; n++) begin
      cycle(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 32'($urandom),
            1'($urandom), 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Parametrised multi-read-port register file for the pipelined CPU. It replaces the fixed 32x32 two-read-port register file.
- Adds write-to-read bypass and an optional hardwired zero register. Also adds a pending-write scoreboard so the decoder can detect RAW hazards instead of relying on NOPs in program memory.
- Sits between the instruction decoder (read addresses, issue of destination) and the ALU writeback (write port).

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs_addr  in  NUM_RD*ADDR_WIDTH  read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rs_data  out  NUM_RD*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH].
- rs_busy  out  NUM_RD  combinational: operand at rs_addr[p] has an unresolved pending write.
- wen  in  1  writeback enable.
- wr_addr  in  ADDR_WIDTH  writeback destination.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  an instruction writing issue_rd has been issued.
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction.
- hazard  out  1  OR of rs_busy (decoder stall request).

Behaviour:
- Reset (async assert, sync release by clk): all registers = 0, all rs_data = 0, all busy bits = 0. hazard = 0 and rs_busy = 0 after reset.
- Reset mid-operation: it discards in-flight writes and pending issues immediately.
- Write: on the clk edge with wen=1, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: 1-cycle latency. rs_data[p] at edge n+1 = reg[rs_addr[p]] as sampled at edge n.
- Bypass: if wen=1, wr_addr == rs_addr[p] and the write is not dropped, rs_data[p] <= wr_data (write-first). No stale value is ever returned.
- Zero register: with ZERO_REG=1, rs_addr[p]=0 always yields 0, including under bypass.
- All read ports are independent. Identical addresses on several ports return identical data.
- Scoreboard, one busy bit per register:
  - issue_en=1 sets busy[issue_rd].
  - wen=1 clears busy[wr_addr].
  - When issue_en and wen target the same address in the same cycle, busy stays set (the newer producer wins).
  - issue_rd=0 with ZERO_REG=1 is ignored.
  - wen to a non-busy register is legal: data is written, busy is unchanged.
- rs_busy[p] = busy[rs_addr[p]] AND NOT (wen AND wr_addr == rs_addr[p]). The bypass resolves the hazard in the writeback cycle.
- hazard = |rs_busy. It is purely combinational from the current inputs and busy state, with no added latency.
- Busy set by issue_en at edge n is visible on rs_busy from edge n onward.
- No single-producer tracking: one wen clears busy regardless of how many issues preceded it. The decoder must not issue two writers to the same register while it is busy.
- Out-of-range parameters (NUM_RD > 4) are a synthesis-time error via generate check.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams REG_WIDTH=32 and REG_ADDR_WIDTH=5;
  - ZERO_REG_IDX=0;
  - the operation encodings already used by the decoder/ALU (NOP=000, ADD=001, SUB=010, AND=011, OR=100, XOR=101, LOAD=110).
- One sub-module is natural: regfile_scoreboard. It holds the DEPTH busy bits and the set/clear priority logic, and outputs the busy vector.
- Read ports are a generate loop inside regfile_bypass; no further sub-modules.

Test Plan:
- Reset check: assert rst asynchronously between edges with prior writes to r1=0xDEAD → rs_data=0 and hazard=0 immediately; after release, reading r1 gives 0.
- Basic write/read: write r3=0x0000000E, then next cycle rs_addr[0]=3, rs_addr[1]=3 → both rs_data=0x0000000E one edge later.
- Bypass: same-cycle wen to r5=0x1234 with rs_addr[1]=5 → rs_data[1]=0x1234 at the next edge (not the old value 0).
- Zero register: write r0=0xFFFFFFFF, issue_en with issue_rd=0, then read r0 → rs_data=0 and rs_busy=0 throughout.
- Scoreboard:
  - issue_en with rd=7 → next cycle rs_addr[0]=7 gives rs_busy[0]=1, hazard=1.
  - wen to r7=0x7 in a later cycle → rs_busy[0]=0 in that cycle, rs_data[0]=0x7 next edge, busy cleared afterward.
- Simultaneous issue/write: busy[4]=1, then in one cycle issue_en rd=4 and wen r4=0x9 → busy[4] stays 1; data 0x9 is written and readable.
